// File: rtl/fifo_lane_unpacker.sv
// Pops DIN_W-bit words from a one-cycle-latency FIFO and streams them out as DOUT_W-bit lanes.
// The lanes are emitted LSB first, over a valid/ready handshake, and are framed by a start/length command.
module fifo_lane_unpacker #(
    parameter int DIN_W  = 64,
    parameter int DOUT_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_words,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DIN_W-1:0]  fifo_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DOUT_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);
    localparam int N      = DIN_W / DOUT_W;
    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(N - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_done, w_done_nxt;
    logic [LEN_W-1:0]     r_len, r_req_cnt, r_emit_cnt;
    logic [DIN_W-1:0]     r_hold, r_next;
    logic                 r_hold_v, r_next_v, r_inflight;
    logic [LANE_W-1:0]    r_lane;

    logic                 w_start_ok, w_acc, w_word_end, w_last_word, w_frame_end;
    logic                 w_cap_hold, w_cap_next, w_shift;
    logic [1:0]           w_occ;
    logic [N-1:0][DOUT_W-1:0] w_hold_lanes;

    assign w_hold_lanes = r_hold;
    assign w_start_ok   = (r_state == S_IDLE) && start && (len_words != '0);
    assign w_acc        = r_hold_v && m_ready;
    assign w_word_end   = w_acc && (r_lane == LAST_LANE);
    assign w_last_word  = (r_emit_cnt == r_len - LEN_W'(1));
    assign w_frame_end  = (r_state == S_RUN) && w_word_end && w_last_word;

    // Occupancy counts only registered slots; a slot freeing this cycle is not reused for a new pop.
    assign w_occ      = {1'b0, r_hold_v} + {1'b0, r_next_v} + {1'b0, r_inflight};
    assign fifo_rd_en = (r_state == S_RUN) && !fifo_empty && (r_req_cnt < r_len) && (w_occ < 2'd2);

    assign w_shift    = w_word_end && r_next_v;
    assign w_cap_hold = r_inflight && (!r_hold_v || w_word_end) && !r_next_v;
    assign w_cap_next = r_inflight && !w_cap_hold;

    assign m_valid = r_hold_v;
    assign m_data  = r_hold_v ? w_hold_lanes[r_lane] : '0;
    assign m_last  = r_hold_v && (r_lane == LAST_LANE) && w_last_word;
    assign busy    = (r_state == S_RUN);
    assign done    = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len_words != '0) w_state_nxt = S_RUN;
                    else                 w_done_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_len      <= '0;
            r_req_cnt  <= '0;
            r_emit_cnt <= '0;
            r_hold_v   <= 1'b0;
            r_next_v   <= 1'b0;
            r_inflight <= 1'b0;
            r_lane     <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_start_ok) begin
                r_len      <= len_words;
                r_req_cnt  <= '0;
                r_emit_cnt <= '0;
            end else begin
                if (fifo_rd_en) r_req_cnt  <= r_req_cnt + LEN_W'(1);
                if (w_word_end) r_emit_cnt <= r_emit_cnt + LEN_W'(1);
            end
            r_hold_v <= w_shift || w_cap_hold || (r_hold_v && !w_word_end);
            r_next_v <= w_cap_next || (r_next_v && !w_shift);
            if (w_word_end)  r_lane <= '0;
            else if (w_acc)  r_lane <= r_lane + LANE_W'(1);
        end
    end

    // Word buffers carry data only; their valid bits above decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (w_shift)         r_hold <= r_next;
        else if (w_cap_hold) r_hold <= fifo_dout;
        if (w_cap_next)      r_next <= fifo_dout;
    end

endmodule

// File: tb/tb_fifo_lane_unpacker.sv
// Scoreboard bench for fifo_lane_unpacker: a behavioural FIFO feeds the DUT, expected lanes are queued
// by the stimulus, and a negedge monitor pops and compares them on every handshake.
module tb_fifo_lane_unpacker;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len_words = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    fifo_lane_unpacker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Behavioural FIFO with one-cycle read latency
    logic [63:0] fq[$];
    logic        push_en = 1'b0;
    logic [63:0] push_data = '0;
    logic        flush_req = 1'b0;
    int          pop_total = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            chk("pop_nonempty", 64'(fq.size() > 0), 64'd1);
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            pop_total++;
        end
        if (flush_req) fq.delete();
        if (push_en) fq.push_back(push_data);
        fifo_empty <= (fq.size() == 0);
    end

    // Scoreboard monitor
    logic [16:0] exp_q[$];
    int          hs_total = 0;
    logic        stall_p = 1'b0;
    logic [15:0] stall_d = '0;

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) chk("stall_hold", {m_valid, m_data}, {1'b1, stall_d});
            stall_p = m_valid && !m_ready;
            stall_d = m_data;
            if (m_valid && m_ready) begin
                hs_total++;
                chk("sb_has_entry", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("lane", {m_last, m_data}, e);
                end
            end
        end
    end

    logic [63:0] pend[$];
    logic [3:0]  pat = 4'b1001;

    task automatic push_word(input logic [63:0] w);
        push_en = 1'b1;
        push_data = w;
        @(posedge clk); #1;
        push_en = 1'b0;
    endtask

    task automatic expect_word(input logic [63:0] w, input bit last_word);
        for (int l = 0; l < N; l++)
            exp_q.push_back({last_word && (l == N - 1), w[l*16 +: 16]});
    endtask

    task automatic run_frame(input int len, input bit bp, input int inj, input int budget,
                             input int exp_pops, input string tag,
                             output int first_rd, output int done_cyc,
                             output int rises, output int max_occ);
        int cyc, p0, h0, occ;
        bit got, pv;
        p0 = pop_total; h0 = hs_total;
        first_rd = -1; done_cyc = -1; rises = 0; max_occ = 0; got = 0; pv = 0;
        start = 1'b1; len_words = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (!got && cyc <= budget) begin
            start = (cyc == inj);
            if (cyc == inj) len_words = 16'd9;
            m_ready = bp ? pat[cyc % 4] : 1'b1;
            push_en = 1'b0;
            if (pend.size() > 0 && cyc % 10 == 0) begin
                push_en = 1'b1;
                push_data = pend.pop_front();
            end
            if (fifo_rd_en && first_rd < 0) first_rd = cyc;
            if (m_valid && !pv) rises++;
            pv = m_valid;
            occ = (pop_total - p0) - (hs_total - h0) / N;
            if (occ > max_occ) max_occ = occ;
            if (done) begin
                got = 1;
                done_cyc = cyc;
                chk({tag, "_busy_at_done"}, busy, 1'b0);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0; push_en = 1'b0; m_ready = 1'b1;
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_pops"}, pop_total - p0, exp_pops);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr, dc, rs, mo, h0;
        logic [63:0] w;
        bit reached;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {fifo_rd_en, m_valid, m_data, m_last, busy, done}, '0);
        rst_n = 1'b0;
        @(posedge clk); #1;

        // Single word, timing from start edge
        push_word(64'h4444_3333_2222_1111);
        expect_word(64'h4444_3333_2222_1111, 1'b1);
        run_frame(1, 1'b0, -1, 50, 1, "single", fr, dc, rs, mo);
        chk("single_first_pop_cycle", fr, 1);
        chk("single_done_cycle", dc, 7);

        // Streaming 8 words
        for (int i = 0; i < 8; i++) begin
            w = {16'hA000 + 16'(i*4+3), 16'hA000 + 16'(i*4+2), 16'hA000 + 16'(i*4+1), 16'hA000 + 16'(i*4)};
            push_word(w);
            expect_word(w, i == 7);
        end
        run_frame(8, 1'b0, -1, 100, 8, "stream", fr, dc, rs, mo);
        chk("stream_valid_runs", rs, 1);

        // Backpressure
        push_word(64'hB004_B003_B002_B001);
        push_word(64'hB008_B007_B006_B005);
        expect_word(64'hB004_B003_B002_B001, 1'b0);
        expect_word(64'hB008_B007_B006_B005, 1'b1);
        run_frame(2, 1'b1, -1, 100, 2, "bp", fr, dc, rs, mo);
        chk("bp_max_buffered_le2", 64'(mo <= 2), 64'd1);

        // Empty FIFO, words arriving every 10 cycles
        pend.push_back(64'hC004_C003_C002_C001);
        pend.push_back(64'hC008_C007_C006_C005);
        pend.push_back(64'hC00C_C00B_C00A_C009);
        expect_word(64'hC004_C003_C002_C001, 1'b0);
        expect_word(64'hC008_C007_C006_C005, 1'b0);
        expect_word(64'hC00C_C00B_C00A_C009, 1'b1);
        run_frame(3, 1'b0, -1, 200, 3, "empty", fr, dc, rs, mo);
        chk("empty_valid_runs", rs, 3);
        chk("empty_done_after_word3", 64'(dc > 30), 64'd1);

        // Start while busy is ignored; 6 words available, only 4 taken
        for (int i = 0; i < 6; i++) begin
            w = {16'hD000 + 16'(i*4+3), 16'hD000 + 16'(i*4+2), 16'hD000 + 16'(i*4+1), 16'hD000 + 16'(i*4)};
            push_word(w);
            if (i < 4) expect_word(w, i == 3);
        end
        run_frame(4, 1'b0, 3, 100, 4, "busy_start", fr, dc, rs, mo);

        // Length zero with data still queued
        @(posedge clk); #1;
        run_frame(0, 1'b0, -1, 20, 0, "len0", fr, dc, rs, mo);
        chk("len0_done_cycle", dc, 1);

        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;

        // Reset during lane 2 of word 1
        push_word(64'hE004_E003_E002_E001);
        push_word(64'hE008_E007_E006_E005);
        expect_word(64'hE004_E003_E002_E001, 1'b0);
        expect_word(64'hE008_E007_E006_E005, 1'b1);
        h0 = hs_total;
        reached = 0;
        start = 1'b1; len_words = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 60 && !reached; c++) begin
            if (hs_total - h0 == 6) reached = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rst_mid_reached_lane", reached, 1'b1);
        chk("rst_mid_lane_data", m_data, 16'hE007);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        chk("rst_mid_outputs", {fifo_rd_en, m_valid, m_data, m_last, busy, done}, '0);
        exp_q.delete();
        @(posedge clk); #1;

        push_word(64'hF004_F003_F002_F001);
        expect_word(64'hF004_F003_F002_F001, 1'b1);
        run_frame(1, 1'b0, -1, 50, 1, "post_rst", fr, dc, rs, mo);
        chk("post_rst_done_cycle", dc, 7);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
